// File: rtl/wb_multi_lane.sv
// rtl/wb_multi_lane.sv - multi-lane write-back stage with conflict resolution and serialising trace FIFO
//
// Registers up to LANES retiring instructions from MEM under the stall bus,
// drives per-lane register-file writes (a younger lane overrides an older
// lane writing the same register), and serialises retirements through a
// trace FIFO onto the single-port debug interface.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   stall[5:0]           stall bus; bit 4 = this stage, bit 5 = downstream
//   flush                clears the pipeline register
//   mem_to_wb_bus        LANES x {valid, pc, we, waddr, wdata}
//   wb_to_rf_bus         LANES x {we, waddr, wdata}
//   wb_to_id_bus         copy of wb_to_rf_bus for ID bypass
//   stallreq_wb          trace FIFO cannot guarantee room for LANES entries
//   trace_overflow       sticky; a trace entry was dropped
//   debug_wb_*           trace FIFO head (all zero when empty)
module wb_multi_lane #(
  parameter int LANES       = 2,
  parameter int PC_W        = 32,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic [5:0]                                stall,
  input  logic                                      flush,
  input  logic [LANES*(2+PC_W+ADDR_W+DATA_W)-1:0]   mem_to_wb_bus,
  output logic [LANES*(1+ADDR_W+DATA_W)-1:0]        wb_to_rf_bus,
  output logic [LANES*(1+ADDR_W+DATA_W)-1:0]        wb_to_id_bus,
  output logic                                      stallreq_wb,
  output logic                                      trace_overflow,
  output logic [PC_W-1:0]                           debug_wb_pc,
  output logic [3:0]                                debug_wb_rf_wen,
  output logic [ADDR_W-1:0]                         debug_wb_rf_wnum,
  output logic [DATA_W-1:0]                         debug_wb_rf_wdata
);

  localparam int LW    = 2 + PC_W + ADDR_W + DATA_W;
  localparam int RW    = 1 + ADDR_W + DATA_W;
  localparam int TW    = PC_W + 1 + ADDR_W + DATA_W;
  localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int CNT_W = $clog2(TRACE_DEPTH) + 1;
  localparam int CW1   = CNT_W + 1;

  logic [LANES*LW-1:0] r_bus;
  logic [TW-1:0]       r_mem [TRACE_DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_overflow;

  logic                w_load;
  logic                w_pop;
  logic [CW1-1:0]      w_room;
  logic [CW1-1:0]      w_npush;
  logic                w_drop;
  logic                w_push_ok  [LANES];
  logic [PTR_W-1:0]    w_push_idx [LANES];
  logic                w_kill     [LANES];
  logic [TW-1:0]       w_head;
  logic                w_unused;

  // Only a real load pushes trace entries; hold and bubble never do, so a
  // held instruction is traced exactly once.
  assign w_load = !flush && !stall[4];
  assign w_pop  = (r_count != '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_bus <= '0;
    end else if (flush) begin
      r_bus <= '0;
    end else if (stall[4] && !stall[5]) begin
      r_bus <= '0;
    end else if (!stall[4]) begin
      r_bus <= mem_to_wb_bus;
    end
  end

  // Younger-lane-wins: an older lane's write is suppressed when any younger
  // valid lane writes the same register.
  always_comb begin
    wb_to_rf_bus = '0;
    for (int i = 0; i < LANES; i++) begin
      w_kill[i] = 1'b0;
      for (int j = i + 1; j < LANES; j++) begin
        if (r_bus[j*LW+LW-1] && r_bus[j*LW+DATA_W+ADDR_W] &&
            (r_bus[j*LW+DATA_W +: ADDR_W] == r_bus[i*LW+DATA_W +: ADDR_W])) begin
          w_kill[i] = 1'b1;
        end
      end
      wb_to_rf_bus[i*RW +: RW] = {r_bus[i*LW+LW-1] & r_bus[i*LW+DATA_W+ADDR_W] & ~w_kill[i],
                                  r_bus[i*LW+DATA_W +: ADDR_W],
                                  r_bus[i*LW +: DATA_W]};
    end
  end

  assign wb_to_id_bus = wb_to_rf_bus;

  // Room counts this edge's pop, so a full FIFO still accepts one push
  // while it drains. Valid lanes claim slots in lane order.
  always_comb begin
    w_room  = CW1'(TRACE_DEPTH) - CW1'(r_count) + CW1'(w_pop);
    w_npush = '0;
    w_drop  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      w_push_ok[k]  = 1'b0;
      w_push_idx[k] = '0;
      if (w_load && mem_to_wb_bus[k*LW+LW-1]) begin
        if (w_npush < w_room) begin
          w_push_ok[k]  = 1'b1;
          w_push_idx[k] = PTR_W'((int'(r_wptr) + int'(w_npush)) % TRACE_DEPTH);
          w_npush       = w_npush + 1'b1;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int k = 0; k < LANES; k++) begin
        if (w_push_ok[k]) begin
          r_mem[w_push_idx[k]] <= mem_to_wb_bus[k*LW +: TW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rptr <= PTR_W'((int'(r_rptr) + 1) % TRACE_DEPTH);
      end
      r_wptr  <= PTR_W'((int'(r_wptr) + int'(w_npush)) % TRACE_DEPTH);
      r_count <= CNT_W'(CW1'(r_count) + w_npush - CW1'(w_pop));
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Uses the registered count only; ignoring this cycle's pop is conservative.
  assign stallreq_wb    = (r_count > CNT_W'(TRACE_DEPTH - LANES));
  assign trace_overflow = r_overflow;

  assign w_head            = w_pop ? r_mem[r_rptr] : '0;
  assign debug_wb_pc       = w_head[TW-1 -: PC_W];
  assign debug_wb_rf_wen   = {4{w_head[DATA_W+ADDR_W]}};
  assign debug_wb_rf_wnum  = w_head[DATA_W +: ADDR_W];
  assign debug_wb_rf_wdata = w_head[DATA_W-1:0];

  // Stall bits 0..3 belong to earlier stages; the registered PC is only
  // needed through the trace path.
  assign w_unused = ^{stall[3:0], r_bus};

endmodule

// File: tb/tb_wb_multi_lane.sv
// tb/tb_wb_multi_lane.sv - directed self-checking bench for wb_multi_lane
module tb_wb_multi_lane;
  localparam int LANES  = 2;
  localparam int PC_W   = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int TD     = 4;
  localparam int LW     = 2 + PC_W + ADDR_W + DATA_W;
  localparam int RW     = 1 + ADDR_W + DATA_W;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [5:0]            stall;
  logic                  flush;
  logic [LANES*LW-1:0]   mem_to_wb_bus;
  logic [LANES*RW-1:0]   wb_to_rf_bus;
  logic [LANES*RW-1:0]   wb_to_id_bus;
  logic                  stallreq_wb;
  logic                  trace_overflow;
  logic [PC_W-1:0]       debug_wb_pc;
  logic [3:0]            debug_wb_rf_wen;
  logic [ADDR_W-1:0]     debug_wb_rf_wnum;
  logic [DATA_W-1:0]     debug_wb_rf_wdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_multi_lane #(
    .LANES(LANES), .PC_W(PC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TRACE_DEPTH(TD)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .stall             (stall),
    .flush             (flush),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .wb_to_rf_bus      (wb_to_rf_bus),
    .wb_to_id_bus      (wb_to_id_bus),
    .stallreq_wb       (stallreq_wb),
    .trace_overflow    (trace_overflow),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  function automatic logic [LW-1:0] lane(input logic v, input logic [PC_W-1:0] pc, input logic we,
                                         input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    return {v, pc, we, wa, wd};
  endfunction

  function automatic logic [RW-1:0] rfl(input logic we, input logic [ADDR_W-1:0] wa,
                                        input logic [DATA_W-1:0] wd);
    return {we, wa, wd};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dbg(input string tag, input logic [PC_W-1:0] pc, input logic [3:0] wen,
                         input logic [ADDR_W-1:0] wn, input logic [DATA_W-1:0] wd);
    chk({tag, ".pc"},    debug_wb_pc,       pc);
    chk({tag, ".wen"},   debug_wb_rf_wen,   wen);
    chk({tag, ".wnum"},  debug_wb_rf_wnum,  wn);
    chk({tag, ".wdata"}, debug_wb_rf_wdata, wd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [159:0] rnd;

    // 1. Reset with random bus
    rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    resetn = 1'b0; stall = 6'b0; flush = 1'b0;
    mem_to_wb_bus = rnd[LANES*LW-1:0];
    step(); step();
    chk("rst.rf", wb_to_rf_bus, '0);
    chk("rst.id", wb_to_id_bus, '0);
    chk("rst.stallreq", stallreq_wb, 1'b0);
    chk("rst.ovf", trace_overflow, 1'b0);
    chk_dbg("rst.dbg", '0, 4'h0, '0, '0);
    resetn = 1'b1; mem_to_wb_bus = '0;
    step();
    chk("rst1.rf", wb_to_rf_bus, '0);
    chk_dbg("rst1.dbg", '0, 4'h0, '0, '0);

    // 2. Single retire
    mem_to_wb_bus = {lane(1'b0, '0, 1'b0, '0, '0), lane(1'b1, 32'hBFC00000, 1'b1, 5'd5, 32'h1234)};
    step();
    mem_to_wb_bus = '0;
    chk("t2.rf0", wb_to_rf_bus[RW-1:0], rfl(1'b1, 5'd5, 32'h1234));
    chk("t2.rf1", wb_to_rf_bus[2*RW-1:RW], rfl(1'b0, 5'd0, 32'h0));
    chk_dbg("t2.dbg", 32'hBFC00000, 4'hF, 5'd5, 32'h1234);
    step();
    chk_dbg("t2.empty", '0, 4'h0, '0, '0);

    // 3. Dual ordering and same-register conflict
    mem_to_wb_bus = {lane(1'b1, 32'h104, 1'b1, 5'd3, 32'hBBBB), lane(1'b1, 32'h100, 1'b1, 5'd3, 32'hAAAA)};
    step();
    mem_to_wb_bus = '0;
    chk("t3.rf0", wb_to_rf_bus[RW-1:0], rfl(1'b0, 5'd3, 32'hAAAA));
    chk("t3.rf1", wb_to_rf_bus[2*RW-1:RW], rfl(1'b1, 5'd3, 32'hBBBB));
    chk("t3.id",  wb_to_id_bus, {rfl(1'b1, 5'd3, 32'hBBBB), rfl(1'b0, 5'd3, 32'hAAAA)});
    chk("t3.stallreq", stallreq_wb, 1'b0);
    chk_dbg("t3.dbg0", 32'h100, 4'hF, 5'd3, 32'hAAAA);
    step();
    chk_dbg("t3.dbg1", 32'h104, 4'hF, 5'd3, 32'hBBBB);
    step();
    chk_dbg("t3.empty", '0, 4'h0, '0, '0);

    // 4. Backpressure
    mem_to_wb_bus = {lane(1'b1, 32'h204, 1'b0, 5'd2, 32'h22), lane(1'b1, 32'h200, 1'b1, 5'd1, 32'h11)};
    step();
    chk_dbg("t4.a", 32'h200, 4'hF, 5'd1, 32'h11);
    chk("t4.a.stallreq", stallreq_wb, 1'b0);
    mem_to_wb_bus = {lane(1'b1, 32'h20C, 1'b1, 5'd4, 32'h44), lane(1'b1, 32'h208, 1'b1, 5'd3, 32'h33)};
    step();
    chk_dbg("t4.b", 32'h204, 4'h0, 5'd2, 32'h22);
    chk("t4.b.stallreq", stallreq_wb, 1'b1);
    stall = 6'b110000;
    step();
    chk_dbg("t4.c", 32'h208, 4'hF, 5'd3, 32'h33);
    chk("t4.c.stallreq", stallreq_wb, 1'b0);
    chk("t4.c.rf1", wb_to_rf_bus[2*RW-1:RW], rfl(1'b1, 5'd4, 32'h44));
    step();
    chk_dbg("t4.d", 32'h20C, 4'hF, 5'd4, 32'h44);
    step();
    chk_dbg("t4.e", '0, 4'h0, '0, '0);
    chk("t4.ovf", trace_overflow, 1'b0);
    stall = 6'b0; mem_to_wb_bus = '0;
    step();
    chk("t4.rf", wb_to_rf_bus, '0);

    // 6. Bubble, hold and flush
    mem_to_wb_bus = {lane(1'b0, '0, 1'b0, '0, '0), lane(1'b1, 32'h400, 1'b1, 5'd7, 32'h77)};
    step();
    chk("t6.load.rf0", wb_to_rf_bus[RW-1:0], rfl(1'b1, 5'd7, 32'h77));
    chk("t6.load.pc", debug_wb_pc, 32'h400);
    stall = 6'b010000;
    mem_to_wb_bus = {lane(1'b1, 32'h504, 1'b1, 5'd8, 32'h5), lane(1'b1, 32'h500, 1'b1, 5'd9, 32'h6)};
    step();
    chk("t6.bubble.rf", wb_to_rf_bus, '0);
    chk("t6.bubble.pc", debug_wb_pc, 32'h0);
    stall = 6'b0;
    mem_to_wb_bus = {lane(1'b0, '0, 1'b0, '0, '0), lane(1'b1, 32'h600, 1'b1, 5'd9, 32'h99)};
    step();
    chk("t6.h0.rf0", wb_to_rf_bus[RW-1:0], rfl(1'b1, 5'd9, 32'h99));
    chk("t6.h0.pc", debug_wb_pc, 32'h600);
    stall = 6'b110000;
    mem_to_wb_bus = {lane(1'b1, 32'h704, 1'b1, 5'd1, 32'h1), lane(1'b1, 32'h700, 1'b1, 5'd2, 32'h2)};
    step();
    chk("t6.h1.rf0", wb_to_rf_bus[RW-1:0], rfl(1'b1, 5'd9, 32'h99));
    chk("t6.h1.pc", debug_wb_pc, 32'h0);
    step();
    chk("t6.h2.rf0", wb_to_rf_bus[RW-1:0], rfl(1'b1, 5'd9, 32'h99));
    chk("t6.h2.pc", debug_wb_pc, 32'h0);
    step();
    chk("t6.h3.rf0", wb_to_rf_bus[RW-1:0], rfl(1'b1, 5'd9, 32'h99));
    chk("t6.h3.pc", debug_wb_pc, 32'h0);
    stall = 6'b0;
    mem_to_wb_bus = {lane(1'b1, 32'h804, 1'b1, 5'd2, 32'h84), lane(1'b1, 32'h800, 1'b1, 5'd1, 32'h80)};
    step();
    chk("t6.f0.pc", debug_wb_pc, 32'h800);
    flush = 1'b1; mem_to_wb_bus = '0;
    step();
    chk("t6.flush.rf", wb_to_rf_bus, '0);
    chk_dbg("t6.flush.dbg", 32'h804, 4'hF, 5'd2, 32'h84);
    flush = 1'b0;
    step();
    chk("t6.f2.pc", debug_wb_pc, 32'h0);

    // 5. Overflow, then reset mid-drain
    mem_to_wb_bus = {lane(1'b1, 32'h304, 1'b1, 5'd2, 32'h2), lane(1'b1, 32'h300, 1'b1, 5'd1, 32'h1)};
    step();
    chk("t5.e1.pc", debug_wb_pc, 32'h300);
    mem_to_wb_bus = {lane(1'b1, 32'h30C, 1'b1, 5'd4, 32'h4), lane(1'b1, 32'h308, 1'b1, 5'd3, 32'h3)};
    step();
    chk("t5.e2.pc", debug_wb_pc, 32'h304);
    chk("t5.e2.stallreq", stallreq_wb, 1'b1);
    mem_to_wb_bus = {lane(1'b1, 32'h314, 1'b1, 5'd6, 32'h6), lane(1'b1, 32'h310, 1'b1, 5'd5, 32'h5)};
    step();
    chk("t5.e3.pc", debug_wb_pc, 32'h308);
    chk("t5.e3.ovf", trace_overflow, 1'b0);
    chk("t5.e3.stallreq", stallreq_wb, 1'b1);
    mem_to_wb_bus = {lane(1'b1, 32'h31C, 1'b1, 5'd8, 32'h8), lane(1'b1, 32'h318, 1'b1, 5'd7, 32'h7)};
    step();
    chk("t5.e4.pc", debug_wb_pc, 32'h30C);
    chk("t5.e4.ovf", trace_overflow, 1'b1);
    mem_to_wb_bus = '0;
    step();
    chk("t5.e5.pc", debug_wb_pc, 32'h310);
    step();
    chk("t5.e6.pc", debug_wb_pc, 32'h314);
    chk("t5.e6.ovf", trace_overflow, 1'b1);
    resetn = 1'b0;
    step();
    chk_dbg("t5.rst.dbg", '0, 4'h0, '0, '0);
    chk("t5.rst.ovf", trace_overflow, 1'b0);
    chk("t5.rst.stallreq", stallreq_wb, 1'b0);
    resetn = 1'b1;
    step();
    chk("t5.post.pc", debug_wb_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
